countdown_sequencer: RTL

Sequences the egg timer's MM:SS countdown datapath and its end-of-cook alarm.
- Accepts a setting-counter value on a load strobe and counts it down in BCD, one step per seconds strobe, while the run enable is high.
- On reaching 00:00 it raises a done flag and drives a fixed beep pattern on the alarm output.
- Sits between the main control FSM (`load`, `run`, `timer_done`) and the display/beeper drivers.

---
 rtl/countdown_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/countdown_sequencer.sv
// MM:SS BCD countdown with end-of-cook alarm for the egg timer.
// Loads clamped setting digits, counts down on seconds strobes, then beeps a fixed pattern.
module countdown_sequencer #(
  parameter int ALARM_BEEPS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       beat_tick,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] set_min_tens,
  input  logic [3:0] set_min_ones,
  input  logic [3:0] set_sec_tens,
  input  logic [3:0] set_sec_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       alarm,
  output logic       armed
);

  typedef enum logic [1:0] {IDLE, ARMED, ALARM, DONE} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(2 * ALARM_BEEPS - 1);

  state_t     state_reg;
  logic [3:0] count_reg [4];
  logic [3:0] beat_cnt_reg;
  logic       timer_done_reg;
  logic       alarm_reg;
  logic       armed_reg;

  // Digit index 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
  logic [3:0] set_digit  [4];
  logic [3:0] load_digit [4];
  logic [3:0] dec_digit  [4];
  logic [3:0] cur_is_zero;
  logic [3:0] load_is_zero;
  logic [3:0] dec_is_zero;

  assign set_digit[0] = set_sec_ones;
  assign set_digit[1] = set_sec_tens;
  assign set_digit[2] = set_min_ones;
  assign set_digit[3] = set_min_tens;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // Ones digits roll over at 9, tens digits at 5.
      localparam logic [3:0] LIMIT = (gi % 2 == 0) ? 4'd9 : 4'd5;
      localparam logic [3:0] LOWER = 4'((1 << gi) - 1);
      logic borrow_in;

      assign cur_is_zero[gi]  = (count_reg[gi] == 4'd0);
      assign borrow_in        = ((cur_is_zero & LOWER) == LOWER);
      assign load_digit[gi]   = (set_digit[gi] > LIMIT) ? LIMIT : set_digit[gi];
      assign dec_digit[gi]    = !borrow_in ? count_reg[gi] :
                                (cur_is_zero[gi] ? LIMIT : count_reg[gi] - 4'd1);
      assign load_is_zero[gi] = (load_digit[gi] == 4'd0);
      assign dec_is_zero[gi]  = (dec_digit[gi] == 4'd0);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      for (int i = 0; i < 4; i++) count_reg[i] <= 4'd0;
      beat_cnt_reg   <= 4'd0;
      timer_done_reg <= 1'b0;
      alarm_reg      <= 1'b0;
      armed_reg      <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < 4; i++) count_reg[i] <= load_digit[i];
      beat_cnt_reg   <= 4'd0;
      timer_done_reg <= 1'b0;
      alarm_reg      <= 1'b0;
      if (&load_is_zero) begin
        state_reg <= IDLE;
        armed_reg <= 1'b0;
      end else begin
        state_reg <= ARMED;
        armed_reg <= 1'b1;
      end
    end else begin
      case (state_reg)
        ARMED: begin
          if (sec_tick && run) begin
            for (int i = 0; i < 4; i++) count_reg[i] <= dec_digit[i];
            if (&dec_is_zero) begin
              state_reg      <= ALARM;
              armed_reg      <= 1'b0;
              timer_done_reg <= 1'b1;
              alarm_reg      <= 1'b1;
              beat_cnt_reg   <= 4'd0;
            end
          end
        end
        ALARM: begin
          // Dropping run acknowledges the alarm and silences it at once.
          if (!run) begin
            state_reg <= DONE;
            alarm_reg <= 1'b0;
          end else if (beat_tick) begin
            beat_cnt_reg <= beat_cnt_reg + 4'd1;
            if (beat_cnt_reg + 4'd1 == LAST_BEAT) begin
              state_reg <= DONE;
              alarm_reg <= 1'b0;
            end else begin
              alarm_reg <= ~alarm_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sec_ones   = count_reg[0];
  assign sec_tens   = count_reg[1];
  assign min_ones   = count_reg[2];
  assign min_tens   = count_reg[3];
  assign timer_done = timer_done_reg;
  assign alarm      = alarm_reg;
  assign armed      = armed_reg;

endmodule
